// File: rtl/bsg_axil_to_fifo_mc.sv
// bsg_axil_to_fifo_mc: AXI-Lite slave exposing per-channel TX/RX FIFOs (push/pop, occupancy, free slots, status).
module bsg_axil_to_fifo_mc #(
  parameter int addr_width_p   = 32,
  parameter int data_width_p   = 32,
  parameter int num_channels_p = 4,
  parameter int tx_els_p       = 8,
  parameter int rx_els_p       = 16
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [addr_width_p-1:0]                araddr_i,
  input  logic                                   arvalid_i,
  output logic                                   arready_o,
  output logic [data_width_p-1:0]                rdata_o,
  output logic [1:0]                             rresp_o,
  output logic                                   rvalid_o,
  input  logic                                   rready_i,
  input  logic [addr_width_p-1:0]                awaddr_i,
  input  logic                                   awvalid_i,
  output logic                                   awready_o,
  input  logic [data_width_p-1:0]                wdata_i,
  input  logic [data_width_p/8-1:0]              wstrb_i,
  input  logic                                   wvalid_i,
  output logic                                   wready_o,
  output logic [1:0]                             bresp_o,
  output logic                                   bvalid_o,
  input  logic                                   bready_i,
  output logic [num_channels_p-1:0]              tx_v_o,
  output logic [num_channels_p*data_width_p-1:0] tx_data_o,
  input  logic [num_channels_p-1:0]              tx_yumi_i,
  input  logic [num_channels_p-1:0]              rx_v_i,
  input  logic [num_channels_p*data_width_p-1:0] rx_data_i,
  output logic [num_channels_p-1:0]              rx_ready_o
);
  localparam int lg_ch_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1;
  localparam int tx_pw_lp = (tx_els_p > 1) ? $clog2(tx_els_p) : 1;
  localparam int rx_pw_lp = (rx_els_p > 1) ? $clog2(rx_els_p) : 1;
  localparam int tx_cw_lp = $clog2(tx_els_p + 1);
  localparam int rx_cw_lp = $clog2(rx_els_p + 1);
  typedef enum logic {R_IDLE, R_RESP} rstate_e;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  rstate_e r_rstate, w_rnext;
  wstate_e r_wstate, w_wnext;
  logic [data_width_p-1:0] r_rdata;
  logic [1:0]              r_rresp, r_bresp;
  logic [lg_ch_lp-1:0]     w_ar_ch, w_aw_ch;
  logic [1:0]              w_ar_off, w_aw_off;
  logic                    w_ar_hs, w_aw_hs, w_aw_ok, w_wr_ok, w_rx_ne;
  logic [data_width_p-1:0] w_rd_data;
  logic [1:0]              w_rd_resp;
  logic [num_channels_p-1:0] w_tx_full, w_rx_full, w_rx_empty;
  logic [tx_cw_lp-1:0]     w_tx_free [num_channels_p];
  logic [rx_cw_lp-1:0]     w_rx_cnt  [num_channels_p];
  logic [data_width_p-1:0] w_rx_head [num_channels_p];
  logic                    w_unused;
  assign w_unused = ^{araddr_i, awaddr_i};
  assign w_ar_ch  = (num_channels_p > 1) ? araddr_i[4 +: lg_ch_lp] : '0;
  assign w_aw_ch  = (num_channels_p > 1) ? awaddr_i[4 +: lg_ch_lp] : '0;
  assign w_ar_off = araddr_i[3:2];
  assign w_aw_off = awaddr_i[3:2];
  // Handshakes are masked during reset so nothing completes while reset_n_i=0.
  assign arready_o = reset_n_i & (r_rstate == R_IDLE);
  assign rvalid_o  = reset_n_i & (r_rstate == R_RESP);
  assign w_ar_hs   = arvalid_i & arready_o;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;
  assign w_rx_ne   = ~w_rx_empty[w_ar_ch];
  assign w_rd_data = (w_ar_off == 2'd0) ? (w_rx_ne ? w_rx_head[w_ar_ch] : data_width_p'(32'hDEADBEEF))
                   : (w_ar_off == 2'd1) ? data_width_p'(w_rx_cnt[w_ar_ch])
                   : (w_ar_off == 2'd2) ? data_width_p'(w_tx_free[w_ar_ch])
                   : data_width_p'({w_rx_ne, w_tx_full[w_ar_ch]});
  assign w_rd_resp = ((w_ar_off == 2'd0) & ~w_rx_ne) ? 2'b10 : 2'b00;
  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  w_rnext = w_ar_hs ? R_RESP : R_IDLE;
      R_RESP:  w_rnext = rready_i ? R_IDLE : R_RESP;
      default: w_rnext = R_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      r_rstate <= w_rnext;
      if (w_ar_hs) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
      end
    end
  end
  assign w_aw_ok   = (w_aw_off != 2'd0) | ~w_tx_full[w_aw_ch];
  assign awready_o = reset_n_i & (r_wstate == W_IDLE) & awvalid_i & wvalid_i & w_aw_ok;
  assign wready_o  = awready_o;
  assign w_aw_hs   = awready_o;
  assign w_wr_ok   = (w_aw_off == 2'd0) & (&wstrb_i);
  assign bvalid_o  = reset_n_i & (r_wstate == W_RESP);
  assign bresp_o   = r_bresp;
  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE:  w_wnext = w_aw_hs ? W_RESP : W_IDLE;
      W_RESP:  w_wnext = bready_i ? W_IDLE : W_RESP;
      default: w_wnext = W_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wstate <= W_IDLE;
      r_bresp  <= 2'b00;
    end else begin
      r_wstate <= w_wnext;
      if (w_aw_hs) r_bresp <= w_wr_ok ? 2'b00 : 2'b10;
    end
  end
  for (genvar c = 0; c < num_channels_p; c++) begin : ch
    logic [data_width_p-1:0] r_tx_mem [tx_els_p];
    logic [data_width_p-1:0] r_rx_mem [rx_els_p];
    logic [tx_pw_lp-1:0]     r_tx_wp, r_tx_rp;
    logic [rx_pw_lp-1:0]     r_rx_wp, r_rx_rp;
    logic [tx_cw_lp-1:0]     r_tx_cnt;
    logic [rx_cw_lp-1:0]     r_rx_cnt;
    logic                    w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    assign w_tx_full[c]  = r_tx_cnt == tx_cw_lp'(tx_els_p);
    assign w_rx_full[c]  = r_rx_cnt == rx_cw_lp'(rx_els_p);
    assign w_rx_empty[c] = r_rx_cnt == '0;
    assign w_tx_free[c]  = tx_cw_lp'(tx_els_p) - r_tx_cnt;
    assign w_rx_cnt[c]   = r_rx_cnt;
    assign w_rx_head[c]  = r_rx_mem[r_rx_rp];
    assign tx_v_o[c]     = reset_n_i & (r_tx_cnt != '0);
    assign tx_data_o[c*data_width_p +: data_width_p] = r_tx_mem[r_tx_rp];
    assign rx_ready_o[c] = reset_n_i & ~w_rx_full[c];
    assign w_tx_push = w_aw_hs & w_wr_ok & (w_aw_ch == lg_ch_lp'(c));
    assign w_tx_pop  = tx_yumi_i[c] & tx_v_o[c];
    assign w_rx_push = rx_v_i[c] & rx_ready_o[c];
    assign w_rx_pop  = w_ar_hs & (w_ar_off == 2'd0) & (w_ar_ch == lg_ch_lp'(c)) & ~w_rx_empty[c];
    always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
        r_tx_wp  <= '0;
        r_tx_rp  <= '0;
        r_tx_cnt <= '0;
        r_rx_wp  <= '0;
        r_rx_rp  <= '0;
        r_rx_cnt <= '0;
      end else begin
        if (w_tx_push) r_tx_wp <= (r_tx_wp == tx_pw_lp'(tx_els_p-1)) ? '0 : r_tx_wp + tx_pw_lp'(1);
        if (w_tx_pop)  r_tx_rp <= (r_tx_rp == tx_pw_lp'(tx_els_p-1)) ? '0 : r_tx_rp + tx_pw_lp'(1);
        if (w_rx_push) r_rx_wp <= (r_rx_wp == rx_pw_lp'(rx_els_p-1)) ? '0 : r_rx_wp + rx_pw_lp'(1);
        if (w_rx_pop)  r_rx_rp <= (r_rx_rp == rx_pw_lp'(rx_els_p-1)) ? '0 : r_rx_rp + rx_pw_lp'(1);
        r_tx_cnt <= r_tx_cnt + tx_cw_lp'(w_tx_push) - tx_cw_lp'(w_tx_pop);
        r_rx_cnt <= r_rx_cnt + rx_cw_lp'(w_rx_push) - rx_cw_lp'(w_rx_pop);
      end
    end
    always_ff @(posedge clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata_i;
      if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data_i[c*data_width_p +: data_width_p];
    end
  end
endmodule

// File: tb/tb_bsg_axil_to_fifo_mc.sv
// tb_bsg_axil_to_fifo_mc: directed self-checking bench for bsg_axil_to_fifo_mc.
module tb_bsg_axil_to_fifo_mc;
  logic         clk_i = 0, reset_n_i = 0;
  logic [31:0]  araddr_i = 0, awaddr_i = 0, wdata_i = 0;
  logic         arvalid_i = 0, rready_i = 0, awvalid_i = 0, wvalid_i = 0, bready_i = 0;
  logic [3:0]   wstrb_i = 0, tx_yumi_i = 0, rx_v_i = 0;
  logic [127:0] rx_data_i = 0;
  logic         arready_o, rvalid_o, awready_o, wready_o, bvalid_o;
  logic [31:0]  rdata_o;
  logic [1:0]   rresp_o, bresp_o;
  logic [3:0]   tx_v_o, rx_ready_o;
  logic [127:0] tx_data_o;
  int total = 0, bad = 0;

  bsg_axil_to_fifo_mc dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .araddr_i(araddr_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rdata_o(rdata_o), .rresp_o(rresp_o), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .awaddr_i(awaddr_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .tx_v_o(tx_v_o), .tx_data_o(tx_data_o), .tx_yumi_i(tx_yumi_i),
    .rx_v_i(rx_v_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input string tag, input logic [1:0] eresp);
    int n;
    awaddr_i = a; wdata_i = d; wstrb_i = s; awvalid_i = 1; wvalid_i = 1;
    #1;
    n = 0;
    while (!awready_o && n < 20) begin
      tick(); #1; n++;
    end
    chk({tag, "_aw"}, {awready_o, wready_o}, 2'b11);
    tick();
    awvalid_i = 0; wvalid_i = 0;
    chk({tag, "_bvalid"}, bvalid_o, 1);
    chk({tag, "_bresp"}, bresp_o, eresp);
    bready_i = 1;
    tick();
    bready_i = 0;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] ed,
                    input logic [1:0] eresp);
    int n;
    araddr_i = a; arvalid_i = 1;
    #1;
    n = 0;
    while (!arready_o && n < 20) begin
      tick(); #1; n++;
    end
    chk({tag, "_ar"}, arready_o, 1);
    tick();
    arvalid_i = 0;
    chk({tag, "_rvalid"}, rvalid_o, 1);
    chk({tag, "_rdata"}, rdata_o, ed);
    chk({tag, "_rresp"}, rresp_o, eresp);
    rready_i = 1;
    tick();
    rready_i = 0;
  endtask

  initial begin
    @(negedge clk_i);
    repeat (3) tick();
    reset_n_i = 1;
    #1;
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_txv", tx_v_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_resps", {rresp_o, bresp_o}, 0);
    chk("rst_rxready", rx_ready_o, 4'hf);
    chk("rst_arready", arready_o, 1);
    chk("rst_awwready", {awready_o, wready_o}, 0);
    tick();

    // Two pushes to channel 2, then drain them through tx_yumi_i.
    wr(32'h20, 32'h11, 4'hf, "ch2_w0", 2'b00);
    wr(32'h20, 32'h22, 4'hf, "ch2_w1", 2'b00);
    chk("ch2_txv", tx_v_o, 4'b0100);
    chk("ch2_head0", tx_data_o[95:64], 32'h11);
    tx_yumi_i[2] = 1;
    tick();
    chk("ch2_head1", tx_data_o[95:64], 32'h22);
    chk("ch2_txv1", tx_v_o, 4'b0100);
    tick();
    tx_yumi_i = 0;
    chk("ch2_empty", tx_v_o, 0);

    // Single RX entry on channel 1.
    rx_v_i[1] = 1; rx_data_i[63:32] = 32'hA5;
    #1;
    chk("ch1_rxready", rx_ready_o[1], 1);
    tick();
    rx_v_i = 0;
    rd(32'h14, "ch1_occ", 32'd1, 2'b00);
    rd(32'h1C, "ch1_stat", 32'd2, 2'b00);
    rd(32'h10, "ch1_pop", 32'hA5, 2'b00);
    rd(32'h10, "ch1_empty", 32'hDEADBEEF, 2'b10);

    // Fill channel 0 TX, then a ninth write must stall until a dequeue.
    for (int i = 0; i < 8; i++) wr(32'h00, 32'h100 + i, 4'hf, "ch0_fill", 2'b00);
    rd(32'h08, "ch0_free_full", 32'd0, 2'b00);
    rd(32'h0C, "ch0_stat_full", 32'd1, 2'b00);
    awaddr_i = 32'h00; wdata_i = 32'h108; wstrb_i = 4'hf; awvalid_i = 1; wvalid_i = 1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("ch0_stall", {awready_o, wready_o}, 0);
      tick(); #1;
    end
    tx_yumi_i[0] = 1;
    #1;
    chk("ch0_stall_yumi", awready_o, 0);
    chk("ch0_yumi_head", tx_data_o[31:0], 32'h100);
    tick();
    tx_yumi_i = 0;
    #1;
    chk("ch0_unstall", {awready_o, wready_o}, 2'b11);
    tick();
    awvalid_i = 0; wvalid_i = 0;
    chk("ch0_w9_bvalid", bvalid_o, 1);
    chk("ch0_w9_bresp", bresp_o, 2'b00);
    bready_i = 1;
    tick();
    bready_i = 0;
    rd(32'h08, "ch0_free_after", 32'd0, 2'b00);
    tx_yumi_i[0] = 1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk("ch0_drain", {tx_v_o[0], tx_data_o[31:0]}, {1'b1, 32'h100 + i});
      tick();
    end
    tx_yumi_i = 0;
    #1;
    chk("ch0_drained", tx_v_o, 0);
    tick();

    // Partial strobes and non-data offsets are rejected without side effects.
    wr(32'h00, 32'h55, 4'b0111, "ch0_strb", 2'b10);
    chk("ch0_strb_notx", tx_v_o[0], 0);
    wr(32'h0C, 32'h1, 4'hf, "ch0_off3", 2'b10);
    rd(32'h08, "ch0_free_empty", 32'd8, 2'b00);

    // Backpressure on R: data held, no new AR accepted until the R handshake.
    rx_v_i[1] = 1; rx_data_i[63:32] = 32'h77;
    tick();
    rx_v_i = 0;
    araddr_i = 32'h10; arvalid_i = 1;
    #1;
    chk("bp_ar", arready_o, 1);
    tick();
    arvalid_i = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rvalid_o, arready_o, rdata_o}, {1'b1, 1'b0, 32'h77});
      tick();
    end
    rready_i = 1; araddr_i = 32'h14; arvalid_i = 1;
    #1;
    chk("bp_ar_blocked", arready_o, 0);
    tick();
    chk("bp_ar_next", {arready_o, rvalid_o}, 2'b10);
    tick();
    arvalid_i = 0;
    chk("bp_r2", {rvalid_o, rdata_o, rresp_o}, {1'b1, 32'd0, 2'b00});
    tick();
    rready_i = 0;

    // Reset in the middle of a pending B response with RX data buffered.
    rx_v_i[3] = 1;
    for (int i = 1; i <= 3; i++) begin
      rx_data_i[127:96] = i;
      tick();
    end
    rx_v_i = 0;
    rd(32'h34, "ch3_occ", 32'd3, 2'b00);
    awaddr_i = 32'h34; wdata_i = 32'h9; wstrb_i = 4'hf; awvalid_i = 1; wvalid_i = 1;
    #1;
    chk("mid_aw", awready_o, 1);
    tick();
    awvalid_i = 0; wvalid_i = 0;
    chk("mid_bvalid", bvalid_o, 1);
    reset_n_i = 0;
    tick();
    reset_n_i = 1;
    #1;
    chk("mid_rst_bvalid", bvalid_o, 0);
    chk("mid_rst_rxready", rx_ready_o, 4'hf);
    tick();
    rd(32'h34, "ch3_occ_rst", 32'd0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
